clk_select_ctrl: RTL and testbench
==================================

Name: clk_select_ctrl

Overview:
- Generates the select line for the downstream glitch-free clock mux that chooses between the programmable clock and the stable clock.
- Runs entirely on the stable clock. It measures the programmable clock's toggle rate and watches its lock indicator.
- It selects the programmable clock only after that clock has qualified over several measurement windows.
- It falls back to the stable clock immediately on any fault.

Parameters:
- WINDOW_CYCLES, 1024: length of one measurement window in clk cycles (>=4, <=65535).
- MIN_EDGES, 60: minimum toggle edges per window for a good window.
- MAX_EDGES, 68: maximum toggle edges per window for a good window (MIN_EDGES <= MAX_EDGES <= 65534).
- QUAL_WINDOWS, 4: consecutive good windows required before the programmable clock is selected (1..255).
- HOLDOFF_CYCLES, 256: clk cycles spent in HOLDOFF before requalification may begin (1..65535).

Ports:
- clk, input, 1: stable reference clock. This block's only clock.
- resetn, input, 1: asynchronous active-low reset.
- prog_locked, input, 1: lock flag of the programmable clock source. Asynchronous; 2-flop synchronized internally.
- prog_toggle, input, 1: divided toggle from the programmable clock domain. Asynchronous; 2-flop synchronized plus 1 history flop.
- force_stable, input, 1: synchronous request to use or stay on the stable clock.
- clk_select, output, 1: mux select. 1 = stable clock, 0 = programmable clock.
- prog_active, output, 1: high while in PROG.
- fault_pulse, output, 1: single-cycle pulse on a fault-caused fallback.
- state, output, 2: FSM state. 0 = HOLDOFF, 1 = IDLE, 2 = QUALIFY, 3 = PROG.

Behaviour:
- Reset (asynchronous, active-low): state = HOLDOFF, clk_select = 1, prog_active = 0, fault_pulse = 0. All counters and synchronizer flops are cleared to 0.
- Synchronization:
  - locked_s is prog_locked after 2 flops.
  - edge is (sync toggle XOR history flop). It is a 1-cycle pulse, 3 clk cycles after a prog_toggle transition.
  - Both rising and falling transitions count as edges.
- Edge counter: 16 bits, saturating at 65535. Increments on edge; counts only in QUALIFY and PROG.
- Window counter:
  - Cleared to 0 on entry to QUALIFY.
  - Counts 0..WINDOW_CYCLES-1 in QUALIFY and PROG, then wraps to 0.
  - The window closes on the cycle the count is WINDOW_CYCLES-1. The evaluated edge count includes an edge occurring in that cycle.
  - A window is good if MIN_EDGES <= count <= MAX_EDGES.
  - The edge count restarts at 0 for the next window.
- HOLDOFF:
  - clk_select = 1. The holdoff counter counts 0..HOLDOFF_CYCLES-1.
  - On the last count, go to IDLE. Inputs are ignored during HOLDOFF.
- IDLE:
  - clk_select = 1.
  - If locked_s = 1 and force_stable = 0, go to QUALIFY. Clear the good-window count and the window and edge counters.
- QUALIFY:
  - clk_select = 1.
  - If locked_s = 0 or force_stable = 1, go to IDLE with no fault_pulse.
  - Otherwise, at window close:
    - Bad window: good count = 0, stay in QUALIFY.
    - Good window: good count + 1. When it reaches QUAL_WINDOWS, go to PROG. clk_select goes to 0 on the same clock edge that state becomes PROG.
- PROG:
  - clk_select = 0, prog_active = 1. Monitoring continues with the same window rules.
  - Exit to HOLDOFF is taken in the cycle the condition is seen. clk_select = 1 and prog_active = 0 on that edge. The holdoff counter restarts at 0.
  - Exit conditions: locked_s = 0, a bad window at close, or force_stable = 1.
  - fault_pulse = 1 for exactly that one cycle if the exit cause includes lock loss or a bad window. This applies even when force_stable is also high.
  - A force_stable-only exit produces no fault_pulse.
- Priority when conditions coincide: reset > lock loss / force_stable > window evaluation.
- No combinational path from any input to any output. All outputs are registered.
- A mid-operation reset returns everything to the reset values immediately, regardless of state.

Test Plan (bench parameters WINDOW_CYCLES=16, MIN_EDGES=3, MAX_EDGES=5, QUAL_WINDOWS=2, HOLDOFF_CYCLES=8):
- Happy path:
  - Stimulus: release resetn with prog_locked=1, force_stable=0, prog_toggle flipping every 4 clk (4 edges/window).
  - Required: state goes HOLDOFF for 8 cycles, then IDLE, then QUALIFY. clk_select falls to 0 at the close of the 2nd good window, with state = 3 and prog_active = 1.
- Bad rate during qualification:
  - Stimulus: toggle every 2 clk (8 edges/window) for 3 windows, then every 4 clk.
  - Required: clk_select stays 1 throughout the bad windows. clk_select = 0 only after 2 consecutive good windows.
- Boundary counts:
  - Stimulus: windows containing exactly 3 edges and exactly 5 edges, then windows of 2 and 6 edges, including an edge on the window's last cycle.
  - Required: 3 and 5 are counted good; 2 and 6 are bad; the last-cycle edge is included in its window.
- Lock loss in PROG:
  - Stimulus: drop prog_locked while in PROG.
  - Required: 2 sync cycles later, clk_select = 1, state = 0, fault_pulse high for 1 cycle. Requalification begins only after the 8-cycle holdoff.
- force_stable:
  - Stimulus: assert force_stable in PROG; separately, assert it together with a bad-window close.
  - Required: in the first case, clk_select = 1 next edge with no fault_pulse. In the second case, fault_pulse = 1. In both cases the FSM holds in IDLE while force_stable = 1.
- Reset mid-PROG:
  - Stimulus: assert resetn = 0 asynchronously while in PROG.
  - Required: clk_select = 1, state = 0, prog_active = 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/clk_select_ctrl.sv
// Clock-mux select controller: qualifies the programmable clock by toggle rate and lock,
// latency 3 clk from async inputs to FSM reaction; no backpressure, all outputs registered.
module clk_select_ctrl #(
  parameter int WINDOW_CYCLES  = 1024,
  parameter int MIN_EDGES      = 60,
  parameter int MAX_EDGES      = 68,
  parameter int QUAL_WINDOWS   = 4,
  parameter int HOLDOFF_CYCLES = 256
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       prog_locked,
  input  logic       prog_toggle,
  input  logic       force_stable,
  output logic       clk_select,
  output logic       prog_active,
  output logic       fault_pulse,
  output logic [1:0] state
);

  localparam logic [1:0] S_HOLDOFF = 2'd0;
  localparam logic [1:0] S_IDLE    = 2'd1;
  localparam logic [1:0] S_QUALIFY = 2'd2;
  localparam logic [1:0] S_PROG    = 2'd3;

  localparam logic [15:0] WIN_LAST  = 16'(WINDOW_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_CYCLES - 1);
  localparam logic [15:0] EDGE_MIN  = 16'(MIN_EDGES);
  localparam logic [15:0] EDGE_MAX  = 16'(MAX_EDGES);
  localparam logic [7:0]  QUAL_LAST = 8'(QUAL_WINDOWS - 1);

  logic        r_lock_s1, r_lock_s2;
  logic        r_tog_s1, r_tog_s2, r_tog_h;
  logic [1:0]  r_state;
  logic        r_clk_sel, r_prog_active, r_fault;
  logic [15:0] r_hold_cnt, r_win_cnt, r_edge_cnt;
  logic [7:0]  r_good_cnt;

  logic        w_locked, w_edge, w_win_last, w_good, w_monitor, w_bad_close;
  logic [15:0] w_edge_sum;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
      r_tog_s1  <= 1'b0;
      r_tog_s2  <= 1'b0;
      r_tog_h   <= 1'b0;
    end else begin
      r_lock_s1 <= prog_locked;
      r_lock_s2 <= r_lock_s1;
      r_tog_s1  <= prog_toggle;
      r_tog_s2  <= r_tog_s1;
      r_tog_h   <= r_tog_s2;
    end
  end

  assign w_locked    = r_lock_s2;
  assign w_edge      = r_tog_s2 ^ r_tog_h;
  assign w_monitor   = (r_state == S_QUALIFY) || (r_state == S_PROG);
  assign w_win_last  = (r_win_cnt == WIN_LAST);
  // Count seen at window close includes an edge landing in the closing cycle.
  assign w_edge_sum  = (r_edge_cnt == 16'hFFFF) ? r_edge_cnt : r_edge_cnt + {15'd0, w_edge};
  assign w_good      = (w_edge_sum >= EDGE_MIN) && (w_edge_sum <= EDGE_MAX);
  assign w_bad_close = w_win_last && !w_good;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_HOLDOFF;
      r_clk_sel     <= 1'b1;
      r_prog_active <= 1'b0;
      r_fault       <= 1'b0;
      r_hold_cnt    <= 16'd0;
      r_win_cnt     <= 16'd0;
      r_edge_cnt    <= 16'd0;
      r_good_cnt    <= 8'd0;
    end else begin
      r_fault <= 1'b0;
      if (w_monitor) begin
        if (w_win_last) begin
          r_win_cnt  <= 16'd0;
          r_edge_cnt <= 16'd0;
        end else begin
          r_win_cnt  <= r_win_cnt + 16'd1;
          r_edge_cnt <= w_edge_sum;
        end
      end
      case (r_state)
        S_HOLDOFF: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= 16'd0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 16'd1;
          end
        end
        S_IDLE: begin
          if (w_locked && !force_stable) begin
            r_state    <= S_QUALIFY;
            r_win_cnt  <= 16'd0;
            r_edge_cnt <= 16'd0;
            r_good_cnt <= 8'd0;
          end
        end
        S_QUALIFY: begin
          if (!w_locked || force_stable) begin
            r_state <= S_IDLE;
          end else if (w_win_last) begin
            if (!w_good) begin
              r_good_cnt <= 8'd0;
            end else if (r_good_cnt == QUAL_LAST) begin
              r_state       <= S_PROG;
              r_clk_sel     <= 1'b0;
              r_prog_active <= 1'b1;
              r_good_cnt    <= 8'd0;
            end else begin
              r_good_cnt <= r_good_cnt + 8'd1;
            end
          end
        end
        default: begin
          // A bad close still flags a fault even if force_stable wins the exit.
          if (!w_locked || force_stable || w_bad_close) begin
            r_state       <= S_HOLDOFF;
            r_clk_sel     <= 1'b1;
            r_prog_active <= 1'b0;
            r_hold_cnt    <= 16'd0;
            r_fault       <= !w_locked || w_bad_close;
          end
        end
      endcase
    end
  end

  assign clk_select  = r_clk_sel;
  assign prog_active = r_prog_active;
  assign fault_pulse = r_fault;
  assign state       = r_state;

endmodule

// File: tb/tb_clk_select_ctrl.sv
// Directed bench for clk_select_ctrl with small windows (16 clk, 3..5 edges, 2 windows, 8 holdoff).
module tb_clk_select_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       prog_locked = 1'b0;
  logic       prog_toggle = 1'b0;
  logic       force_stable = 1'b0;
  logic       clk_select;
  logic       prog_active;
  logic       fault_pulse;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int tog_period = 0;
  int tog_cnt = 0;
  int tidx = 0;
  logic [127:0] sched = '0;

  clk_select_ctrl #(
    .WINDOW_CYCLES(16), .MIN_EDGES(3), .MAX_EDGES(5), .QUAL_WINDOWS(2), .HOLDOFF_CYCLES(8)
  ) dut (
    .clk(clk), .resetn(resetn), .prog_locked(prog_locked), .prog_toggle(prog_toggle),
    .force_stable(force_stable), .clk_select(clk_select), .prog_active(prog_active),
    .fault_pulse(fault_pulse), .state(state)
  );

  always #5 clk = ~clk;

  // One clock: inputs change just after posedge, caller samples at the following negedge.
  task automatic tick(input logic man_tog);
    @(posedge clk);
    #1;
    if (man_tog) prog_toggle = ~prog_toggle;
    if (tog_period != 0) begin
      tog_cnt++;
      if (tog_cnt >= tog_period) begin
        tog_cnt = 0;
        prog_toggle = ~prog_toggle;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] tgt, input int budget, output int n);
    n = 0;
    while (state !== tgt && n < budget) begin
      tick(1'b0);
      n++;
    end
  endtask

  // A toggle applied in tick i is counted at tick i+3 after QUALIFY entry.
  task automatic drive_to(input int upto);
    while (tidx < upto) begin
      tidx++;
      tick(sched[tidx+3]);
    end
  endtask

  task automatic do_reset(input int period, input logic lk);
    resetn = 1'b0;
    force_stable = 1'b0;
    prog_locked = lk;
    prog_toggle = 1'b0;
    tog_period = period;
    tog_cnt = 0;
    repeat (3) tick(1'b0);
    resetn = 1'b1;
  endtask

  task automatic get_to_prog();
    int n;
    do_reset(4, 1'b1);
    wait_state(2'd3, 80, n);
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL reach_prog: state=%0d expected 3", state); end
  endtask

  task automatic enter_qualify_manual();
    int n;
    do_reset(0, 1'b1);
    wait_state(2'd2, 40, n);
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL reach_qualify: state=%0d expected 2", state); end
    tidx = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    prog_locked = 1'b1;
    tick(1'b0);
    tick(1'b0);
    checks++;
    if ({state, clk_select, prog_active, fault_pulse} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_values: st=%0d sel=%0b act=%0b flt=%0b expected 0 1 0 0",
               state, clk_select, prog_active, fault_pulse);
    end
  endtask

  task automatic test_happy_path();
    int hold, q;
    do_reset(4, 1'b1);
    hold = 0;
    while (state === 2'd0 && hold < 40) begin hold++; tick(1'b0); end
    checks++;
    if (hold !== 8) begin errors++; $display("FAIL holdoff_len: got %0d expected 8", hold); end
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL after_holdoff: state=%0d expected 1", state); end
    tick(1'b0);
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL idle_to_qualify: state=%0d expected 2", state); end
    q = 0;
    while (state === 2'd2 && clk_select === 1'b1 && q < 80) begin q++; tick(1'b0); end
    checks++;
    if (q !== 32) begin errors++; $display("FAIL qualify_len: got %0d expected 32", q); end
    checks++;
    if ({state, clk_select, prog_active} !== 4'b1101) begin
      errors++;
      $display("FAIL prog_entry: st=%0d sel=%0b act=%0b expected 3 0 1", state, clk_select, prog_active);
    end
  endtask

  task automatic test_bad_rate();
    int n;
    logic saw_low;
    do_reset(2, 1'b1);
    wait_state(2'd2, 40, n);
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL bad_rate_qualify: state=%0d expected 2", state); end
    saw_low = 1'b0;
    for (int i = 1; i <= 48; i++) begin
      tick(1'b0);
      if (clk_select !== 1'b1) saw_low = 1'b1;
    end
    tog_period = 4;
    tog_cnt = 0;
    for (int i = 49; i <= 79; i++) begin
      tick(1'b0);
      if (clk_select !== 1'b1) saw_low = 1'b1;
    end
    checks++;
    if (saw_low !== 1'b0) begin errors++; $display("FAIL bad_rate_select: got low expected stays 1"); end
    wait_state(2'd3, 40, n);
    checks++;
    if ({state, clk_select} !== 3'b110) begin
      errors++; $display("FAIL bad_rate_recover: st=%0d sel=%0b expected 3 0", state, clk_select);
    end
  endtask

  task automatic test_boundary();
    // 3 edges (last on window's final cycle), then 5: PROG; 5 in PROG good, 6 bad.
    enter_qualify_manual();
    sched = '0;
    sched[4] = 1; sched[8] = 1; sched[16] = 1;
    sched[20] = 1; sched[24] = 1; sched[28] = 1; sched[30] = 1; sched[32] = 1;
    sched[36] = 1; sched[40] = 1; sched[44] = 1; sched[46] = 1; sched[48] = 1;
    sched[52] = 1; sched[54] = 1; sched[56] = 1; sched[58] = 1; sched[60] = 1; sched[62] = 1;
    drive_to(31);
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL edges3_early: state=%0d expected 2", state); end
    drive_to(32);
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL edges3_5_good: state=%0d expected 3", state); end
    drive_to(48);
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL edges5_prog: state=%0d expected 3", state); end
    drive_to(64);
    checks++;
    if ({state, fault_pulse} !== 3'b001) begin
      errors++; $display("FAIL edges6_bad: st=%0d flt=%0b expected 0 1", state, fault_pulse);
    end
    // 2 edges bad, then 3 and 3 good; 2 edges in PROG faults.
    enter_qualify_manual();
    sched = '0;
    sched[4] = 1; sched[10] = 1;
    sched[20] = 1; sched[26] = 1; sched[32] = 1;
    sched[36] = 1; sched[42] = 1; sched[48] = 1;
    sched[52] = 1; sched[58] = 1;
    drive_to(32);
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL edges2_bad: state=%0d expected 2", state); end
    drive_to(48);
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL edges2_recover: state=%0d expected 3", state); end
    drive_to(64);
    checks++;
    if ({state, fault_pulse} !== 3'b001) begin
      errors++; $display("FAIL edges2_prog_bad: st=%0d flt=%0b expected 0 1", state, fault_pulse);
    end
  endtask

  task automatic test_lock_loss();
    int hold;
    get_to_prog();
    prog_locked = 1'b0;
    tick(1'b0);
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL lock_loss_early: state=%0d expected 3", state); end
    tick(1'b0);
    tick(1'b0);
    checks++;
    if ({state, clk_select, prog_active, fault_pulse} !== 5'b00101) begin
      errors++;
      $display("FAIL lock_loss_exit: st=%0d sel=%0b act=%0b flt=%0b expected 0 1 0 1",
               state, clk_select, prog_active, fault_pulse);
    end
    prog_locked = 1'b1;
    hold = 1;
    tick(1'b0);
    checks++;
    if (fault_pulse !== 1'b0) begin errors++; $display("FAIL lock_loss_pulse_len: flt=%0b expected 0", fault_pulse); end
    while (state === 2'd0 && hold < 40) begin hold++; tick(1'b0); end
    checks++;
    if (hold !== 8) begin errors++; $display("FAIL lock_loss_holdoff: got %0d expected 8", hold); end
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL lock_loss_idle: state=%0d expected 1", state); end
    tick(1'b0);
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL lock_loss_requal: state=%0d expected 2", state); end
  endtask

  task automatic test_force_stable();
    int n;
    logic left_idle;
    get_to_prog();
    force_stable = 1'b1;
    tick(1'b0);
    checks++;
    if ({state, clk_select, fault_pulse} !== 4'b0010) begin
      errors++; $display("FAIL force_exit: st=%0d sel=%0b flt=%0b expected 0 1 0", state, clk_select, fault_pulse);
    end
    wait_state(2'd1, 20, n);
    left_idle = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      if (state !== 2'd1) left_idle = 1'b1;
    end
    checks++;
    if (left_idle !== 1'b0) begin errors++; $display("FAIL force_hold_idle: left IDLE expected stay 1"); end
    force_stable = 1'b0;
    tick(1'b0);
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL force_release: state=%0d expected 2", state); end
    // force_stable coinciding with a bad-window close in PROG still faults.
    enter_qualify_manual();
    sched = '0;
    sched[4] = 1; sched[8] = 1; sched[16] = 1;
    sched[20] = 1; sched[24] = 1; sched[28] = 1;
    sched[40] = 1; sched[44] = 1;
    drive_to(47);
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL force_bad_pre: state=%0d expected 3", state); end
    force_stable = 1'b1;
    drive_to(48);
    checks++;
    if ({state, clk_select, fault_pulse} !== 4'b0011) begin
      errors++; $display("FAIL force_bad_close: st=%0d sel=%0b flt=%0b expected 0 1 1", state, clk_select, fault_pulse);
    end
    wait_state(2'd1, 20, n);
    repeat (15) tick(1'b0);
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL force_bad_idle: state=%0d expected 1", state); end
    force_stable = 1'b0;
  endtask

  task automatic test_reset_mid_prog();
    get_to_prog();
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({state, clk_select, prog_active, fault_pulse} !== 5'b00100) begin
      errors++;
      $display("FAIL async_reset: st=%0d sel=%0b act=%0b flt=%0b expected 0 1 0 0",
               state, clk_select, prog_active, fault_pulse);
    end
    tick(1'b0);
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_happy_path();
    test_bad_rate();
    test_boundary();
    test_lock_loss();
    test_force_stable();
    test_reset_mid_prog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
